// File: rtl/clk_rst_gen_if.sv
// clk_rst_gen_if: generated clock/reset bundle driven by clk_rst_gen
interface clk_rst_gen_if;
    logic        clk_o;
    logic        rst_no;
    logic        rst_done_o;
    logic [31:0] clk_cnt_o;
    modport master (output clk_o, rst_no, rst_done_o, clk_cnt_o);
    modport slave  (input  clk_o, rst_no, rst_done_o, clk_cnt_o);
endinterface

// File: rtl/clk_rst_gen_div.sv
// clk_rst_gen_div: divides clk_i by ClkPeriod, flagging the cycles where clk_o rises or falls
module clk_rst_gen_div #(
    parameter int unsigned ClkPeriod = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic clk_o,
    output logic rise_o,
    output logic fall_o
);
    localparam int unsigned Half = ClkPeriod / 2;
    localparam int unsigned DW = Half > 1 ? $clog2(Half) : 1;
    localparam logic [DW-1:0] Last = DW'(Half - 1);
    logic [DW-1:0] div_q;
    logic toggle;
    always_comb begin
        toggle = div_q == Last;
        rise_o = toggle & ~clk_o;
        fall_o = toggle & clk_o;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q <= '0;
            clk_o <= 1'b0;
        end else begin
            div_q <= toggle ? '0 : div_q + 1'b1;
            clk_o <= clk_o ^ toggle;
        end
    end
endmodule

// File: rtl/clk_rst_gen.sv
// clk_rst_gen: divided clock plus an active-low reset held for RstClkCycles clk_o rises
module clk_rst_gen #(
    parameter int unsigned ClkPeriod    = 2,
    parameter int unsigned RstClkCycles = 5
) (
    input logic clk_i,
    input logic rst_i,
    clk_rst_gen_if.master bus
);
    if (ClkPeriod < 2 || ClkPeriod % 2 != 0 || RstClkCycles == 0) begin : g_bad_params
        $fatal(1, "clk_rst_gen: ClkPeriod must be even and >= 2, RstClkCycles >= 1");
    end
    localparam int unsigned CW = RstClkCycles > 0 ? $clog2(RstClkCycles + 1) : 1;
    localparam logic [CW-1:0] RMax = CW'(RstClkCycles);
    logic [CW-1:0] rst_cnt;
    logic rise, fall;
    clk_rst_gen_div #(.ClkPeriod(ClkPeriod)) u_div (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clk_o (bus.clk_o),
        .rise_o(rise),
        .fall_o(fall)
    );
    // release only on a falling edge so the clk_o domain sees a clean rst_no setup
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rst_cnt        <= '0;
            bus.rst_no     <= 1'b0;
            bus.rst_done_o <= 1'b0;
            bus.clk_cnt_o  <= '0;
        end else begin
            rst_cnt <= (rise && !bus.rst_no && rst_cnt != RMax) ? rst_cnt + 1'b1 : rst_cnt;
            if (fall && rst_cnt == RMax) begin
                bus.rst_no     <= 1'b1;
                bus.rst_done_o <= 1'b1;
            end
            bus.clk_cnt_o <= (rise && bus.clk_cnt_o != '1) ? bus.clk_cnt_o + 1'b1 : bus.clk_cnt_o;
        end
    end
endmodule

// File: tb/tb_clk_rst_gen.sv
// tb_clk_rst_gen: directed checks of two clk_rst_gen configurations (2/5 and 6/2)
module tb_clk_rst_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int passed = 0, total = 0;
    int n = 0;
    int lowrise0 = 0, lowrise1 = 0, last0 = 0, last1 = 0, per0 = 0, per1 = 0;
    logic p0c, p0r, p1c, p1r, r0, r1;

    clk_rst_gen_if b0();
    clk_rst_gen_if b1();
    clk_rst_gen #(.ClkPeriod(2), .RstClkCycles(5)) u0 (.clk_i(clk), .rst_i(rst), .bus(b0));
    clk_rst_gen #(.ClkPeriod(6), .RstClkCycles(2)) u1 (.clk_i(clk), .rst_i(rst), .bus(b1));

    always #5 clk = ~clk;

    // advance one clk_i cycle and record rises, periods and rises seen while rst_no was low
    task automatic cycle();
        p0c = b0.clk_o; p0r = b0.rst_no; p1c = b1.clk_o; p1r = b1.rst_no;
        @(posedge clk);
        #1;
        n++;
        r0 = !p0c && b0.clk_o;
        r1 = !p1c && b1.clk_o;
        per0 = 0;
        per1 = 0;
        if (r0) begin
            per0 = last0 != 0 ? n - last0 : 0;
            last0 = n;
            if (!p0r) lowrise0++;
        end
        if (r1) begin
            per1 = last1 != 0 ? n - last1 : 0;
            last1 = n;
            if (!p1r) lowrise1++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin
            cycle();
            total++;
            if (b0.clk_o !== 1'b0 || b0.rst_no !== 1'b0 || b0.rst_done_o !== 1'b0 || b0.clk_cnt_o !== 32'd0)
                $display("FAIL reset_u0 got clk_o=%b rst_no=%b done=%b cnt=%0d, want all 0", b0.clk_o, b0.rst_no, b0.rst_done_o, b0.clk_cnt_o);
            else passed++;
            total++;
            if (b1.clk_o !== 1'b0 || b1.rst_no !== 1'b0 || b1.rst_done_o !== 1'b0 || b1.clk_cnt_o !== 32'd0)
                $display("FAIL reset_u1 got clk_o=%b rst_no=%b done=%b cnt=%0d, want all 0", b1.clk_o, b1.rst_no, b1.rst_done_o, b1.clk_cnt_o);
            else passed++;
        end
    endtask

    // release reset and check the first 14 cycles of both instances against hand-derived waveforms
    task automatic test_sequence();
        logic e0c, e0r, e1c, e1r;
        int e0n, e1n;
        rst = 1'b0;
        n = 0; lowrise0 = 0; lowrise1 = 0; last0 = 0; last1 = 0;
        repeat (14) begin
            cycle();
            e0c = n % 2 == 1;
            e0r = n >= 10;
            e0n = (n + 1) / 2;
            e1c = (n / 3) % 2 == 1;
            e1r = n >= 12;
            e1n = (n + 3) / 6;
            total++;
            if (b0.clk_o !== e0c || b0.rst_no !== e0r || b0.rst_done_o !== e0r || b0.clk_cnt_o !== 32'(e0n))
                $display("FAIL seq_u0 cycle %0d got clk_o=%b rst_no=%b done=%b cnt=%0d, want %b %b %b %0d",
                         n, b0.clk_o, b0.rst_no, b0.rst_done_o, b0.clk_cnt_o, e0c, e0r, e0r, e0n);
            else passed++;
            total++;
            if (b1.clk_o !== e1c || b1.rst_no !== e1r || b1.rst_done_o !== e1r || b1.clk_cnt_o !== 32'(e1n))
                $display("FAIL seq_u1 cycle %0d got clk_o=%b rst_no=%b done=%b cnt=%0d, want %b %b %b %0d",
                         n, b1.clk_o, b1.rst_no, b1.rst_done_o, b1.clk_cnt_o, e1c, e1r, e1r, e1n);
            else passed++;
        end
        total++;
        if (lowrise0 !== 5) $display("FAIL lowrise_u0 got %0d rises with rst_no low, want 5", lowrise0);
        else passed++;
        total++;
        if (lowrise1 !== 2) $display("FAIL lowrise_u1 got %0d rises with rst_no low, want 2", lowrise1);
        else passed++;
    endtask

    task automatic test_long_run();
        while (n < 600) begin
            cycle();
            if (per0 != 0) begin
                total++;
                if (per0 !== 2) $display("FAIL period_u0 cycle %0d got %0d, want 2", n, per0);
                else passed++;
            end
            if (per1 != 0) begin
                total++;
                if (per1 !== 6) $display("FAIL period_u1 cycle %0d got %0d, want 6", n, per1);
                else passed++;
            end
            total++;
            if (b0.rst_no !== 1'b1 || b1.rst_no !== 1'b1)
                $display("FAIL hold_rst_no cycle %0d got u0=%b u1=%b, want 1 1", n, b0.rst_no, b1.rst_no);
            else passed++;
            if (n == 200) begin
                total++;
                if (b0.clk_cnt_o !== 32'd100) $display("FAIL cnt100_u0 got %0d, want 100", b0.clk_cnt_o);
                else passed++;
            end
        end
        total++;
        if (b1.clk_cnt_o !== 32'd100) $display("FAIL cnt100_u1 got %0d, want 100", b1.clk_cnt_o);
        else passed++;
        total++;
        if (b0.clk_cnt_o !== 32'd300) $display("FAIL cnt300_u0 got %0d, want 300", b0.clk_cnt_o);
        else passed++;
        total++;
        if (lowrise0 !== 5 || lowrise1 !== 2)
            $display("FAIL extra_lowrise got u0=%0d u1=%0d, want 5 2", lowrise0, lowrise1);
        else passed++;
    endtask

    task automatic test_mid_reset();
        cycle();
        total++;
        if (b0.clk_o !== 1'b1) $display("FAIL pre_reset_clk_u0 got %b, want 1", b0.clk_o);
        else passed++;
        rst = 1'b1;
        cycle();
        total++;
        if (b0.clk_o !== 1'b0 || b0.rst_no !== 1'b0 || b0.clk_cnt_o !== 32'd0)
            $display("FAIL mid_reset_u0 got clk_o=%b rst_no=%b cnt=%0d, want 0 0 0", b0.clk_o, b0.rst_no, b0.clk_cnt_o);
        else passed++;
        total++;
        if (b1.clk_o !== 1'b0 || b1.rst_no !== 1'b0 || b1.clk_cnt_o !== 32'd0)
            $display("FAIL mid_reset_u1 got clk_o=%b rst_no=%b cnt=%0d, want 0 0 0", b1.clk_o, b1.rst_no, b1.clk_cnt_o);
        else passed++;
        test_sequence();
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_long_run();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
